// File: rtl/mod_arith_pkg.sv
// Shared definitions for the word-serial modular arithmetic blocks (subtractor now, adder later).
// Holds the control state encoding and the default word-slicing geometry.
package mod_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        CORR = 2'd2,
        DONE = 2'd3
    } state_e;

    // Keeps the word counter at least one bit wide when there is a single word.
    function automatic int cnt_width(input int nw);
        return (nw > 1) ? $clog2(nw) : 1;
    endfunction

    localparam int DEF_DATA_WIDTH = 256;
    localparam int DEF_WORD_WIDTH = 64;
    localparam int NW             = DEF_DATA_WIDTH / DEF_WORD_WIDTH;
    localparam int CNT_W          = cnt_width(NW);

endpackage

// File: rtl/word_add_cin.sv
// Combinational WORD_WIDTH-bit adder with carry-in and carry-out.
// One instance is time-shared across all words of an operand.
module word_add_cin #(
    parameter int WORD_WIDTH = 64
) (
    input  logic [WORD_WIDTH-1:0] a_i,
    input  logic [WORD_WIDTH-1:0] b_i,
    input  logic                  cin_i,
    output logic [WORD_WIDTH-1:0] sum_o,
    output logic                  cout_o
);

    logic [WORD_WIDTH:0] full_sum;

    assign full_sum = {1'b0, a_i} + {1'b0, b_i} + {{WORD_WIDTH{1'b0}}, cin_i};
    assign sum_o    = full_sum[WORD_WIDTH-1:0];
    assign cout_o   = full_sum[WORD_WIDTH];

endmodule

// File: rtl/mod_subtractor_serial.sv
// Word-serial modular subtractor: r = (a - b) mod p, computed as a + ~b + 1 one word per cycle,
// followed by a word-serial add-back of p when the subtraction borrows.
module mod_subtractor_serial
    import mod_arith_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic [DATA_WIDTH-1:0] in_p,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_r,
    output logic                  out_corr
);

    localparam int N_WORDS  = DATA_WIDTH / WORD_WIDTH;
    localparam int CNT_BITS = cnt_width(N_WORDS);
    localparam logic [CNT_BITS-1:0] LAST_WORD = CNT_BITS'(N_WORDS - 1);

    state_e                state_q, state_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic                  carry_q, carry_d;
    logic                  corr_q, corr_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] p_q, p_d;
    logic [DATA_WIDTH-1:0] diff_q, diff_d;

    logic [WORD_WIDTH-1:0] a_word, b_word, p_word, diff_word;
    logic [WORD_WIDTH-1:0] op_x, op_y, add_sum;
    logic                  add_cout;
    logic                  last_word;

    assign a_word    = a_q[int'(cnt_q)*WORD_WIDTH +: WORD_WIDTH];
    assign b_word    = b_q[int'(cnt_q)*WORD_WIDTH +: WORD_WIDTH];
    assign p_word    = p_q[int'(cnt_q)*WORD_WIDTH +: WORD_WIDTH];
    assign diff_word = diff_q[int'(cnt_q)*WORD_WIDTH +: WORD_WIDTH];
    assign last_word = (cnt_q == LAST_WORD);

    // SUB pass feeds a + ~b; CORR pass feeds diff + p through the same adder.
    assign op_x = (state_q == SUB) ? a_word : diff_word;
    assign op_y = (state_q == SUB) ? ~b_word : p_word;

    word_add_cin #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_word_add (
        .a_i    (op_x),
        .b_i    (op_y),
        .cin_i  (carry_q),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid) state_d = SUB;
            SUB:  if (last_word) state_d = add_cout ? DONE : CORR;
            CORR: if (last_word) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        carry_d = carry_q;
        corr_d  = corr_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        diff_d  = diff_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    p_d     = in_p;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    corr_d  = 1'b0;
                end
            end
            SUB, CORR: begin
                diff_d[int'(cnt_q)*WORD_WIDTH +: WORD_WIDTH] = add_sum;
                carry_d = add_cout;
                cnt_d   = last_word ? '0 : cnt_q + CNT_BITS'(1);
                // A clear carry out of the top word of a + ~b + 1 means a < b.
                if (state_q == SUB && last_word && !add_cout) begin
                    corr_d  = 1'b1;
                    carry_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // NOTE: operand and result registers are reset too, so an aborted operation leaves no stale data visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            corr_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            diff_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            corr_q  <= corr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            diff_q  <= diff_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        out_r     = diff_q;
        out_corr  = corr_q;
    end

endmodule

// File: tb/tb_mod_subtractor_serial.sv
// Directed bench for mod_subtractor_serial: hand-computed results, latencies, stall and reset behaviour.
module tb_mod_subtractor_serial;

    localparam int DW = 256;
    localparam logic [DW-1:0] P256 =
        256'hFFFFFFFF00000001_0000000000000000_00000000FFFFFFFF_FFFFFFFFFFFFFFFF;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic [DW-1:0] in_p;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_r;
    logic          out_corr;

    int checks = 0;
    int errors = 0;

    mod_subtractor_serial #(
        .DATA_WIDTH (256),
        .WORD_WIDTH (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_p      (in_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_corr  (out_corr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for in_ready, then presents operands for exactly one accept edge.
    task automatic start_op(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [DW-1:0] p);
        int waited = 0;
        while (!in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check({tag, " in_ready before accept"}, in_ready, 1);
        in_a     = a;
        in_b     = b;
        in_p     = p;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_result(input string tag, input int exp_lat);
        int cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " latency"}, cyc, exp_lat);
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " out_valid after out_ready"}, out_valid, 0);
        check({tag, " in_ready after out_ready"}, in_ready, 1);
    endtask

    task automatic run_op(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [DW-1:0] p, input logic [DW-1:0] exp_r,
                          input logic exp_corr, input int exp_lat);
        start_op(tag, a, b, p);
        wait_result(tag, exp_lat);
        check({tag, " out_r"}, out_r, exp_r);
        check({tag, " out_corr"}, out_corr, exp_corr);
        release_result(tag);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_p      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset out_r", out_r, 0);
        check("reset out_corr", out_corr, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("small no-borrow", 256'd10, 256'd3, 256'd97, 256'd7, 1'b0, 4);
        run_op("small borrow", 256'd3, 256'd10, 256'd97, 256'd90, 1'b1, 8);
        run_op("a equals b", 256'd7, 256'd7, 256'd97, 256'd0, 1'b0, 4);
        run_op("zero minus p-1", 256'd0, 256'd96, 256'd97, 256'd1, 1'b1, 8);
        run_op("p256 full ripple", 256'd0, 256'd1, P256,
               256'hFFFFFFFF00000001_0000000000000000_00000000FFFFFFFF_FFFFFFFFFFFFFFFE, 1'b1, 8);
        run_op("word0/1 borrow", 256'h1_0000000000000000, 256'd1, P256,
               256'h0000000000000000_0000000000000000_0000000000000000_FFFFFFFFFFFFFFFF, 1'b0, 4);

        // Result held under back-pressure while in_valid is pulsed with other operands.
        start_op("stall", 256'd50, 256'd20, 256'd97);
        wait_result("stall", 4);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            in_a     = DW'($urandom);
            in_b     = DW'($urandom);
            @(posedge clk); #1;
            check("stall out_valid held", out_valid, 1);
            check("stall in_ready low", in_ready, 0);
            check("stall out_r held", out_r, 256'd30);
            check("stall out_corr held", out_corr, 0);
        end
        in_valid = 1'b0;
        release_result("stall");

        // Asynchronous reset in the second CORR cycle of a borrowing operation.
        start_op("abort", 256'd3, 256'd10, 256'd97);
        repeat (5) @(posedge clk);
        #1;
        check("abort corr set before reset", out_corr, 1);
        #2 rst = 1'b1;
        #1;
        check("abort out_valid", out_valid, 0);
        check("abort in_ready", in_ready, 1);
        check("abort out_corr cleared", out_corr, 0);
        check("abort out_r cleared", out_r, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_op("after abort", 256'd5, 256'd5, 256'd97, 256'd0, 1'b0, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
